// File: rtl/wb_pin_ctrl_pkg.sv
// rtl/wb_pin_ctrl_pkg.sv - register map and CTRL/STATUS bit positions for wb_pin_ctrl
package wb_pin_ctrl_pkg;

    localparam logic [2:0] CTRL     = 3'd0;
    localparam logic [2:0] STATUS   = 3'd1;
    localparam logic [2:0] OUTVAL   = 3'd2;
    localparam logic [2:0] IRQ_EN   = 3'd3;
    localparam logic [2:0] IRQ_STAT = 3'd4;

    localparam int CTRL_HALT         = 0;
    localparam int CTRL_SRST         = 1;
    localparam int CTRL_OVR          = 2;
    localparam int STATUS_CORE_RESET = 16;

    // Expand the four Wishbone byte selects into a 32-bit write mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_pin_ctrl_pin_sync.sv
// rtl/wb_pin_ctrl_pin_sync.sv - multi-stage input synchroniser with async active-low reset
module pin_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wb_pin_ctrl.sv
// rtl/wb_pin_ctrl.sv - Wishbone pin/control block for the 4-bit CPU; WB_PIN_CTRL_LA_EN adds LA halt/reset inputs
module wb_pin_ctrl
    import wb_pin_ctrl_pkg::*;
#(
    parameter int IN_WIDTH    = 4,
    parameter int OUT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYCLES  = 16
) (
    input  logic                 wb_clock_i,
    input  logic                 wb_reset_ni,
    input  logic                 wb_cyc_i,
    input  logic                 wb_strobe_i,
    input  logic                 wb_we_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_addr_i,
    input  logic [31:0]          wb_data_i,
    output logic [31:0]          wb_data_o,
    output logic                 wb_ack_o,
    input  logic [IN_WIDTH-1:0]  pin_in,
    input  logic [OUT_WIDTH-1:0] core_out,
    output logic [OUT_WIDTH-1:0] pin_out,
    output logic [OUT_WIDTH-1:0] pin_oeb,
    output logic [IN_WIDTH-1:0]  core_in,
    output logic                 core_halt,
    output logic                 core_reset,
    output logic                 irq
`ifdef WB_PIN_CTRL_LA_EN
    ,
    input  logic                 la_halt_i,
    input  logic                 la_reset_i
`endif
);

    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

    logic                 bus_req;
    logic                 wr_en;
    logic                 rd_en;
    logic                 srst_trig;
    logic                 la_halt;
    logic                 la_reset;
    logic [2:0]           reg_idx;
    logic [31:0]          wr_mask;
    logic [31:0]          wr_bits;
    logic [31:0]          rd_data;
    logic                 halt_q;
    logic                 ovr_q;
    logic                 irq_q;
    logic [OUT_WIDTH-1:0] outval_q;
    logic [IN_WIDTH-1:0]  irq_en_q;
    logic [IN_WIDTH-1:0]  irq_stat_q;
    logic [IN_WIDTH-1:0]  prev_q;
    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  w1c;
    logic [7:0]           rst_cnt_q;
    logic                 unused_bits;

    // A request is only accepted while ack is low, so a held strobe acks every other cycle.
    assign bus_req   = wb_cyc_i & wb_strobe_i & ~wb_ack_o;
    assign wr_en     = bus_req & wb_we_i;
    assign rd_en     = bus_req & ~wb_we_i;
    assign reg_idx   = wb_addr_i[4:2];
    assign wr_mask   = byte_mask(wb_sel_i);
    assign wr_bits   = wb_data_i & wr_mask;
    assign srst_trig = wr_en && (reg_idx == CTRL) && wr_bits[CTRL_SRST];

    assign unused_bits = ^{wb_addr_i[31:5], wb_addr_i[1:0], wr_mask, wr_bits};

    pin_sync #(
        .WIDTH  (IN_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk   (wb_clock_i),
        .rst_n (wb_reset_ni),
        .d     (pin_in),
        .q     (core_in)
    );

`ifdef WB_PIN_CTRL_LA_EN
    logic [1:0] la_sync;

    pin_sync #(
        .WIDTH  (2),
        .STAGES (2)
    ) u_la_sync (
        .clk   (wb_clock_i),
        .rst_n (wb_reset_ni),
        .d     ({la_halt_i, la_reset_i}),
        .q     (la_sync)
    );

    assign la_halt  = la_sync[1];
    assign la_reset = la_sync[0];
`else
    assign la_halt  = 1'b0;
    assign la_reset = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            CTRL: begin
                rd_data[CTRL_HALT] = halt_q;
                rd_data[CTRL_OVR]  = ovr_q;
            end
            STATUS: begin
                rd_data[IN_WIDTH-1:0]      = core_in;
                rd_data[STATUS_CORE_RESET] = core_reset;
            end
            OUTVAL:   rd_data[OUT_WIDTH-1:0] = outval_q;
            IRQ_EN:   rd_data[IN_WIDTH-1:0]  = irq_en_q;
            IRQ_STAT: rd_data[IN_WIDTH-1:0]  = irq_stat_q;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            wb_ack_o  <= 1'b0;
            wb_data_o <= '0;
        end else begin
            wb_ack_o  <= bus_req;
            wb_data_o <= rd_en ? rd_data : '0;
        end
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            halt_q   <= 1'b0;
            ovr_q    <= 1'b0;
            outval_q <= '0;
            irq_en_q <= '0;
        end else if (wr_en) begin
            case (reg_idx)
                CTRL: begin
                    if (wb_sel_i[0]) begin
                        halt_q <= wb_data_i[CTRL_HALT];
                        ovr_q  <= wb_data_i[CTRL_OVR];
                    end
                end
                OUTVAL:  outval_q <= (outval_q & ~wr_mask[OUT_WIDTH-1:0]) | wr_bits[OUT_WIDTH-1:0];
                IRQ_EN:  irq_en_q <= (irq_en_q & ~wr_mask[IN_WIDTH-1:0]) | wr_bits[IN_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Edges arriving while the core is held in reset are dropped, not deferred.
    assign rise = core_in & ~prev_q & {IN_WIDTH{~core_reset}};
    assign w1c  = (wr_en && (reg_idx == IRQ_STAT)) ? wr_bits[IN_WIDTH-1:0] : '0;

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            prev_q     <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= core_in;
            irq_stat_q <= (irq_stat_q & ~w1c) | rise;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    // Counter starts loaded so the core stays in reset for RST_CYCLES after power-on.
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            rst_cnt_q <= RST_LOAD;
        end else if (srst_trig || la_reset) begin
            rst_cnt_q <= RST_LOAD;
        end else if (rst_cnt_q != 8'd0) begin
            rst_cnt_q <= rst_cnt_q - 8'd1;
        end
    end

    assign core_reset = (rst_cnt_q != 8'd0);
    assign core_halt  = halt_q | la_halt;
    assign irq        = irq_q;
    assign pin_out    = ovr_q ? outval_q : core_out;
    assign pin_oeb    = {OUT_WIDTH{core_reset & ~ovr_q}};

endmodule

// File: tb/tb_wb_pin_ctrl.sv
// tb/tb_wb_pin_ctrl.sv - self-checking bench for wb_pin_ctrl against a behavioural register/pin model
module tb_wb_pin_ctrl;

    localparam int IN_W  = 4;
    localparam int OUT_W = 8;
    localparam int SYNC  = 2;
    localparam int RSTC  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_strobe_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [31:0] wb_addr_i = 32'd0;
    logic [31:0] wb_data_i = 32'd0;
    logic [31:0] wb_data_o;
    logic        wb_ack_o;
    logic [IN_W-1:0]  pin_in = '0;
    logic [OUT_W-1:0] core_out = '0;
    logic [OUT_W-1:0] pin_out;
    logic [OUT_W-1:0] pin_oeb;
    logic [IN_W-1:0]  core_in;
    logic        core_halt;
    logic        core_reset;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    longint cyc_n = 0;
    longint ack_cyc = 0;

    logic        m_halt = 1'b0;
    logic        m_ovr = 1'b0;
    logic [31:0] m_outval = 32'd0;
    logic [31:0] m_en = 32'd0;
    logic [3:0]  m_stat = 4'd0;
    logic [3:0]  m_pin = 4'd0;
    longint      m_until = 64'h7fff_ffff_ffff;

    wb_pin_ctrl #(
        .IN_WIDTH    (IN_W),
        .OUT_WIDTH   (OUT_W),
        .SYNC_STAGES (SYNC),
        .RST_CYCLES  (RSTC)
    ) dut (
        .wb_clock_i  (clk),
        .wb_reset_ni (rst_n),
        .wb_cyc_i    (wb_cyc_i),
        .wb_strobe_i (wb_strobe_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .wb_data_o   (wb_data_o),
        .wb_ack_o    (wb_ack_o),
        .pin_in      (pin_in),
        .core_out    (core_out),
        .pin_out     (pin_out),
        .pin_oeb     (pin_oeb),
        .core_in     (core_in),
        .core_halt   (core_halt),
        .core_reset  (core_reset),
        .irq         (irq)
`ifdef WB_PIN_CTRL_LA_EN
        ,
        .la_halt_i   (1'b0),
        .la_reset_i  (1'b0)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_crst();
        return cyc_n < m_until;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] idx);
        logic [31:0] r;
        r = 32'd0;
        case (idx)
            3'd0: r = {29'd0, m_ovr, 1'b0, m_halt};
            3'd1: begin r[3:0] = m_pin; r[16] = exp_crst(); end
            3'd2: r = m_outval & 32'hFF;
            3'd3: r = m_en & 32'hF;
            3'd4: r = {28'd0, m_stat};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        int n;
        n = 0;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = we;
        wb_addr_i = {27'd0, idx, 2'b00}; wb_data_i = wdat; wb_sel_i = sel;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb_ack_o && n < 8);
        check("ack_seen", wb_ack_o, 1'b1);
        ack_cyc = cyc_n;
        rdat = wb_data_o;
        wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        check("ack_width", wb_ack_o, 1'b0);
        check("data_idle", wb_data_o, 32'd0);
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        wb_xfer(1'b1, idx, d, sel, r);
        case (idx)
            3'd0: if (sel[0]) begin
                m_halt = d[0];
                m_ovr  = d[2];
                if (d[1]) m_until = ack_cyc + RSTC;
            end
            3'd2: m_outval = merge(m_outval, d, sel);
            3'd3: m_en = merge(m_en, d, sel);
            3'd4: if (sel[0]) m_stat = m_stat & ~d[3:0];
            default: ;
        endcase
    endtask

    task automatic bus_read_check(input string tag, input logic [2:0] idx);
        logic [31:0] r;
        wb_xfer(1'b0, idx, 32'd0, 4'h0, r);
        check(tag, r, exp_rd(idx));
    endtask

    task automatic apply_pins(input logic [3:0] p);
        if (!exp_crst()) m_stat = m_stat | (p & ~m_pin);
        m_pin = p;
        pin_in = p;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_halt"}, core_halt, m_halt);
        check({tag, "_pin_out"}, pin_out, m_ovr ? m_outval[7:0] : core_out);
        check({tag, "_oeb"}, pin_oeb, (exp_crst() && !m_ovr) ? 8'hFF : 8'h00);
        check({tag, "_crst"}, core_reset, exp_crst());
        check({tag, "_irq"}, irq, |(m_stat & m_en[3:0]));
    endtask

    initial begin
        int          op;
        logic [31:0] d;
        logic [3:0]  s;

        // Held in reset
        repeat (3) @(negedge clk);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_data", wb_data_o, 32'd0);
        check("rst_halt", core_halt, 1'b0);
        check("rst_crst", core_reset, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("rst_core_in", core_in, 4'd0);
        check("rst_oeb", pin_oeb, 8'hFF);

        // Release: core_reset for exactly RSTC clocks; an edge inside the window is ignored
        rst_n = 1'b1;
        m_until = cyc_n + RSTC;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) apply_pins(4'b0010);
            @(negedge clk);
            check("rel_crst", core_reset, exp_crst());
            check("rel_oeb", pin_oeb, exp_crst() ? 8'hFF : 8'h00);
            check("rel_ack", wb_ack_o, 1'b0);
        end
        bus_read_check("rel_irq_stat", 3'd4);
        apply_pins(4'b0000);
        repeat (SYNC + 3) @(negedge clk);

        // HALT and ack spacing
        bus_write(3'd0, 32'h1, 4'h1);
        check("halt_set", core_halt, 1'b1);
        bus_read_check("ctrl_rd", 3'd0);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_ack", wb_ack_o, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
        @(negedge clk);

        // Override path
        core_out = 8'h3C;
        bus_write(3'd2, 32'hA5, 4'hF);
        bus_write(3'd0, 32'h4, 4'h1);
        check("ovr_on", pin_out, 8'hA5);
        bus_write(3'd0, 32'h0, 4'h1);
        check("ovr_off", pin_out, 8'h3C);

        // Edge IRQ timing: flag after SYNC+1 clocks, irq one clock later
        bus_write(3'd3, 32'h1, 4'h1);
        @(negedge clk);
        apply_pins(4'b0001);
        for (int i = 1; i <= SYNC + 2; i++) begin
            @(negedge clk);
            check("irq_lat", irq, (i == SYNC + 2) ? 1'b1 : 1'b0);
        end
        bus_read_check("irq_stat_rd", 3'd4);
        bus_write(3'd4, 32'h1, 4'h1);
        check("irq_clr", irq, 1'b0);
        check_outputs("irq_dir");

        // Soft reset with retrigger
        bus_write(3'd0, 32'h2, 4'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("srst_hold", core_reset, 1'b1);
        end
        bus_write(3'd0, 32'h2, 4'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("srst_retrig", core_reset, exp_crst());
            check("srst_oeb", pin_oeb, exp_crst() ? 8'hFF : 8'h00);
        end
        bus_write(3'd0, 32'h6, 4'h1);
        check("srst_ovr_crst", core_reset, 1'b1);
        check("srst_ovr_oeb", pin_oeb, 8'h00);
        repeat (RSTC + 2) @(negedge clk);
        bus_write(3'd0, 32'h0, 4'h1);
        check_outputs("srst_end");

        // Randomised register/pin traffic
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 6);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            case (op)
                0: bus_write(3'd0, d & ~32'h2, s);
                1: bus_write(3'd2, d, s);
                2: bus_write(3'd3, d, s);
                3: bus_write(3'd4, d, s);
                4: bus_read_check("rand_rd", 3'($urandom_range(0, 7)));
                5: begin
                    core_out = 8'($urandom);
                    apply_pins(4'($urandom));
                    repeat (SYNC + 3) @(negedge clk);
                end
                default: bus_write(3'($urandom_range(5, 7)), d, s);
            endcase
            check_outputs("rand");
        end

        // Async reset in the middle of a read
        bus_write(3'd2, 32'hFF, 4'h1);
        bus_write(3'd3, 32'hF, 4'h1);
        bus_write(3'd0, 32'h5, 4'h1);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'd0;
        @(posedge clk); #1;
        check("mid_ack", wb_ack_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ack", wb_ack_o, 1'b0);
        check("arst_data", wb_data_o, 32'd0);
        check("arst_halt", core_halt, 1'b0);
        check("arst_crst", core_reset, 1'b1);
        wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
        m_halt = 1'b0; m_ovr = 1'b0; m_outval = 32'd0; m_en = 32'd0; m_stat = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        m_until = cyc_n + RSTC;
        repeat (RSTC + 2) @(negedge clk);
        check_outputs("arst");
        bus_read_check("arst_ctrl", 3'd0);
        bus_read_check("arst_outval", 3'd2);
        bus_read_check("arst_irq_en", 3'd3);
        bus_read_check("arst_irq_stat", 3'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
